// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates two requesters onto one shared ALU and returns
// each captured result over a valid/ready handshake to the granted requester.
module alu_share_ctrl #(
    parameter int WIDTH = 16,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_z,
    output logic             rsp_n,
    output logic             rsp_v,
    output logic [WIDTH-1:0] alu_ain,
    output logic [WIDTH-1:0] alu_bin,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_v,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic [1:0]       op_q, op_d;
    logic             gid_q, gid_d, pref_q, pref_d;
    logic             z_q, z_d, n_q, n_d, v_q, v_d;
    logic             win, any_req, rsp_hs, idle;

    // pref_q names the requester that wins the next tie
    assign win     = (req0_valid & req1_valid) ? (FAIR ? pref_q : 1'b0) : req1_valid;
    assign any_req = req0_valid | req1_valid;
    assign idle    = (state_q == IDLE) & ~reset;
    assign rsp_hs  = (state_q == RESP) & (gid_q ? rsp1_ready : rsp0_ready);

    assign req0_ready = idle & req0_valid & ~win;
    assign req1_ready = idle & req1_valid & win;
    assign rsp0_valid = (state_q == RESP) & ~gid_q;
    assign rsp1_valid = (state_q == RESP) & gid_q;
    assign busy       = state_q != IDLE;
    assign alu_ain    = a_q;
    assign alu_bin    = b_q;
    assign alu_op     = op_q;
    assign rsp_out    = out_q;
    assign rsp_z      = z_q;
    assign rsp_n      = n_q;
    assign rsp_v      = v_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        gid_d   = gid_q;
        pref_d  = pref_q;
        out_d   = out_q;
        z_d     = z_q;
        n_d     = n_q;
        v_d     = v_q;
        if (state_q == IDLE && any_req) begin
            state_d = EXEC;
            a_d     = win ? req1_a : req0_a;
            b_d     = win ? req1_b : req0_b;
            op_d    = win ? req1_op : req0_op;
            gid_d   = win;
            pref_d  = ~win;
        end else if (state_q == EXEC) begin
            state_d = RESP;
            out_d   = alu_out;
            z_d     = alu_z;
            // N and V are only meaningful for SUB
            n_d     = (op_q == 2'b01) & alu_n;
            v_d     = (op_q == 2'b01) & alu_v;
        end else if (rsp_hs) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            gid_q   <= 1'b0;
            pref_q  <= 1'b0;
            out_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            gid_q   <= gid_d;
            pref_q  <= pref_d;
            out_q   <= out_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed bench with a transaction-level reference model
// checked every cycle, plus literal expectations for the test-plan vectors.
module tb_alu_share_ctrl;
    logic clk = 1'b0, reset = 1'b1, force_nv = 1'b0;
    logic req0_valid = 0, req1_valid = 0, rsp0_ready = 1, rsp1_ready = 1;
    logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [1:0]  req0_op = 0, req1_op = 0;
    logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_z, rsp_n, rsp_v, busy;
    logic [15:0] rsp_out, alu_ain, alu_bin, alu_out;
    logic [1:0]  alu_op;
    logic alu_z, alu_n, alu_v;
    logic f_r0, f_r1, f_v0, f_v1, f_z, f_n, f_v, f_busy, f_az, f_an, f_av;
    logic [15:0] f_out, f_ain, f_bin, f_aout;
    logic [1:0]  f_op;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    // Bench ALU; force drives N/V high to show the block masks them outside SUB
    function automatic logic [18:0] alu_f(logic [15:0] a, logic [15:0] b, logic [1:0] op, logic frc);
        logic [15:0] r;
        r = op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : ~b;
        return {frc | (op == 2'd1 && a[15] != b[15] && r[15] != a[15]), frc | r[15], r == 16'd0, r};
    endfunction

    // Reference result: {v, n, z, out} from plain arithmetic and the flag rule
    function automatic logic [18:0] exp_f(logic [15:0] a, logic [15:0] b, logic [1:0] op);
        logic [15:0] r;
        int d;
        case (op)
            2'd0: r = a + b;
            2'd1: r = a - b;
            2'd2: r = a & b;
            default: r = ~b;
        endcase
        d = int'($signed(a)) - int'($signed(b));
        return {op == 2'd1 && (d > 32767 || d < -32768), op == 2'd1 && r[15], r == 16'd0, r};
    endfunction

    assign {alu_v, alu_n, alu_z, alu_out} = alu_f(alu_ain, alu_bin, alu_op, force_nv);
    assign {f_av, f_an, f_az, f_aout} = alu_f(f_ain, f_bin, f_op, 1'b0);

    alu_share_ctrl #(.WIDTH(16), .FAIR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_out(rsp_out), .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_v(rsp_v),
        .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .busy(busy));

    alu_share_ctrl #(.WIDTH(16), .FAIR(1'b0)) dut_fixed (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(f_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(f_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(f_v0), .rsp0_ready(1'b1), .rsp1_valid(f_v1), .rsp1_ready(1'b1),
        .rsp_out(f_out), .rsp_z(f_z), .rsp_n(f_n), .rsp_v(f_v),
        .alu_ain(f_ain), .alu_bin(f_bin), .alu_op(f_op),
        .alu_out(f_aout), .alu_z(f_az), .alu_n(f_an), .alu_v(f_av), .busy(f_busy));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 executing, 2 holding a response
    int m_cnt = 0;
    logic m_id = 0, m_pref = 0, m_z = 0, m_n = 0, m_v = 0;
    logic [15:0] m_a = 0, m_b = 0, m_res = 0;
    logic [1:0]  m_op = 0;

    always @(negedge clk) begin : cmp
        logic w;
        w = (req0_valid && req1_valid) ? m_pref : req1_valid;
        chk("ready0", req0_ready, !reset && m_cnt == 0 && req0_valid && !w);
        chk("ready1", req1_ready, !reset && m_cnt == 0 && req1_valid && w);
        chk("rsp0_valid", rsp0_valid, !reset && m_cnt == 2 && !m_id);
        chk("rsp1_valid", rsp1_valid, !reset && m_cnt == 2 && m_id);
        chk("busy", busy, !reset && m_cnt != 0);
        chk("rsp_out", rsp_out, reset ? 16'd0 : m_res);
        chk("rsp_flags", {rsp_z, rsp_n, rsp_v}, reset ? 3'd0 : {m_z, m_n, m_v});
        chk("alu_ports", {alu_ain, alu_bin, alu_op}, reset ? 34'd0 : {m_a, m_b, m_op});
        if (reset) begin
            m_cnt <= 0; m_id <= 0; m_pref <= 0; m_a <= 0; m_b <= 0; m_op <= 0;
            m_res <= 0; m_z <= 0; m_n <= 0; m_v <= 0;
        end else if (m_cnt == 0 && (req0_valid || req1_valid)) begin
            m_cnt <= 1; m_id <= w; m_pref <= !w;
            m_a <= w ? req1_a : req0_a;
            m_b <= w ? req1_b : req0_b;
            m_op <= w ? req1_op : req0_op;
        end else if (m_cnt == 1) begin
            {m_v, m_n, m_z, m_res} <= exp_f(m_a, m_b, m_op);
            m_cnt <= 2;
        end else if (m_cnt == 2 && (m_id ? rsp1_ready : rsp0_ready)) begin
            m_cnt <= 0;
        end
    end

    task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                          input logic [15:0] eo, input logic ez, input logic en, input logic ev);
        logic ok;
        int lat;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        chk("accept", ok, 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) chk("exec_operands", {alu_ain, alu_bin, alu_op}, {a, b, op});
            if (id ? rsp1_valid : rsp0_valid) lat = i;
        end
        chk("latency", lat, 2);
        chk("lit_out", rsp_out, eo);
        chk("lit_flags", {rsp_z, rsp_n, rsp_v}, {ez, en, ev});
        @(posedge clk); #1;
    endtask

    initial begin
        int g[4];
        int gi, nr, fr0, fr1, fs0;
        logic got;
        req0_valid = 1;
        @(posedge clk); #1;
        chk("reset_ready0", req0_ready, 0);
        chk("reset_busy", busy, 0);
        req0_valid = 0;
        @(posedge clk); #1;
        reset = 0;
        run_op(0, 16'h0003, 16'h0005, 2'b00, 16'h0008, 0, 0, 0);
        run_op(1, 16'h0005, 16'h0005, 2'b01, 16'h0000, 1, 0, 0);
        run_op(1, 16'h8000, 16'h0001, 2'b01, 16'h7FFF, 0, 0, 1);
        force_nv = 1;
        run_op(0, 16'hF0F0, 16'h0FF0, 2'b10, 16'h00F0, 0, 0, 0);
        run_op(0, 16'h1234, 16'hFFFF, 2'b11, 16'h0000, 1, 0, 0);
        force_nv = 0;
        // Backpressure: response 0 held while requester 1 waits
        rsp0_ready = 0;
        req0_valid = 1; req0_a = 16'd1; req0_b = 16'd1; req0_op = 2'b00;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = req0_ready; end
        chk("bp_accept", got, 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 1; req1_a = 16'd2; req1_b = 16'd1; req1_op = 2'b01;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = rsp0_valid; end
        chk("bp_rsp", got, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", {rsp0_valid, req1_ready, busy, rsp_out, rsp_z, rsp_n, rsp_v}, {3'b101, 16'd2, 3'b000});
        end
        @(posedge clk); #1;
        rsp0_ready = 1;
        @(negedge clk);
        chk("bp_release", {rsp0_valid, req1_ready}, 2'b10);
        @(negedge clk);
        chk("bp_rearb", {req1_ready, busy, rsp0_valid}, 3'b100);
        @(posedge clk); #1;
        req1_valid = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = rsp1_valid; end
        chk("bp_rsp1", {got, rsp_out, rsp_z}, {1'b1, 16'd1, 1'b0});
        @(posedge clk); #1;
        // Both requesters valid continuously, compared across fair and fixed priority
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        req0_valid = 1; req0_a = 16'd1; req0_b = 16'd1; req0_op = 2'b00;
        req1_valid = 1; req1_a = 16'd4; req1_b = 16'd1; req1_op = 2'b01;
        gi = 0; nr = 0; fr0 = 0; fr1 = 0; fs0 = 0;
        repeat (12) begin
            @(negedge clk);
            if ((req0_ready || req1_ready) && gi < 4) begin g[gi] = req1_ready ? 1 : 0; gi++; end
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) nr++;
            if (f_r0) fr0++;
            if (f_r1) fr1++;
            if (f_v0) fs0++;
        end
        chk("fair_grants", gi, 4);
        chk("fair_order", {g[0][0], g[1][0], g[2][0], g[3][0]}, 4'b0101);
        chk("fair_rsps", nr, 4);
        chk("fixed_r0", fr0, 4);
        chk("fixed_r1", fr1, 0);
        chk("fixed_rsp0", fs0, 4);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        // Asynchronous reset while executing
        req0_valid = 1; req0_a = 16'd7; req0_b = 16'd2; req0_op = 2'b01;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = req0_ready; end
        chk("rst_accept", got, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        chk("rst_exec_ain", alu_ain, 16'd7);
        #1 reset = 1;
        #1;
        chk("rst_immediate", {busy, rsp0_valid, alu_ain, alu_op, rsp_out}, 36'd0);
        @(posedge clk); #1;
        reset = 0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_rsp", {rsp0_valid, rsp1_valid, busy}, 3'b000);
        end
        @(posedge clk); #1;
        run_op(0, 16'h7FFF, 16'h0001, 2'b00, 16'h8000, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
